// File: rtl/min_search_pkg.sv
// Shared types and default sizing for the minimum-search controller.
// Optional abort support in min_search_ctrl is enabled with MIN_SEARCH_ABORT_EN.
package min_search_pkg;

  localparam int LANES_DEF  = 8;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam logic [31:0] INIT_MIN_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } state_t;

  // Lane index width that stays legal for a single-lane build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/min_lane_reduce.sv
// Combinational reduction of one ALU group: smallest unmasked lane value and
// the lowest lane index holding it.
module min_lane_reduce
  import min_search_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = idx_width(LANES)
) (
  input  logic [LANES*DATA_W-1:0] values,
  input  logic [LANES-1:0]        mask,
  output logic                    any_valid,
  output logic [DATA_W-1:0]       min_value,
  output logic [IDX_W-1:0]        min_idx
);

  logic [DATA_W-1:0] lane [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_unpack
      assign lane[gi] = values[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Strict compare while scanning upward keeps the lowest index on ties.
  always_comb begin
    any_valid = 1'b0;
    min_value = '1;
    min_idx   = '0;
    for (int k = 0; k < LANES; k++) begin
      if (mask[k] && (!any_valid || (lane[k] < min_value))) begin
        any_valid = 1'b1;
        min_value = lane[k];
        min_idx   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/min_search_ctrl.sv
// Scans num_entries distance results through a grouped ALU array and reports
// the minimum and its address. Define MIN_SEARCH_ABORT_EN to add an abort input.
module min_search_ctrl
  import min_search_pkg::*;
#(
  parameter int                LANES    = LANES_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] INIT_MIN = DATA_W'(INIT_MIN_DEF)
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef MIN_SEARCH_ABORT_EN
  input  logic                    abort,
`endif
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [31:0]             num_entries,
  input  logic                    small_big,
  output logic [ADDR_W-1:0]       alu_addr,
  output logic                    alu_req,
  input  logic                    alu_valid,
  input  logic [LANES*DATA_W-1:0] alu_result,
  output logic                    busy,
  output logic                    done,
  output logic                    found,
  output logic [DATA_W-1:0]       min_value,
  output logic [ADDR_W-1:0]       min_addr
);

  localparam int IDX_W = idx_width(LANES);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       remaining_reg, remaining_next;
  logic              wide_reg, wide_next;
  logic [DATA_W-1:0] run_min_reg, run_min_next;
  logic [ADDR_W-1:0] run_addr_reg, run_addr_next;
  logic              any_group_reg, any_group_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              found_reg, found_next;
  logic [DATA_W-1:0] min_value_reg, min_value_next;
  logic [ADDR_W-1:0] min_addr_reg, min_addr_next;

  logic [31:0]       step;
  logic [31:0]       active;
  logic [31:0]       remaining_after;
  logic [LANES-1:0]  mask;
  logic              red_valid;
  logic [DATA_W-1:0] red_min;
  logic [IDX_W-1:0]  red_idx;

  // Lanes past the entries still owed by this search take no part.
  assign step            = wide_reg ? 32'(LANES) : 32'd1;
  assign active          = (remaining_reg < step) ? remaining_reg : step;
  assign remaining_after = remaining_reg - active;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_mask
      assign mask[gi] = (32'(gi) < active);
    end
  endgenerate

  min_lane_reduce #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_reduce (
    .values    (alu_result),
    .mask      (mask),
    .any_valid (red_valid),
    .min_value (red_min),
    .min_idx   (red_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      wide_reg      <= 1'b0;
      run_min_reg   <= INIT_MIN;
      run_addr_reg  <= '0;
      any_group_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      found_reg     <= 1'b0;
      min_value_reg <= INIT_MIN;
      min_addr_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      wide_reg      <= wide_next;
      run_min_reg   <= run_min_next;
      run_addr_reg  <= run_addr_next;
      any_group_reg <= any_group_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      found_reg     <= found_next;
      min_value_reg <= min_value_next;
      min_addr_reg  <= min_addr_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    wide_next      = wide_reg;
    run_min_next   = run_min_reg;
    run_addr_next  = run_addr_reg;
    any_group_next = any_group_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    found_next     = found_reg;
    min_value_next = min_value_reg;
    min_addr_next  = min_addr_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          wide_next      = small_big;
          addr_next      = base_addr;
          remaining_next = num_entries;
          run_min_next   = INIT_MIN;
          run_addr_next  = base_addr;
          any_group_next = 1'b0;
          busy_next      = 1'b1;
          state_next     = (num_entries == 32'd0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT;
`ifdef MIN_SEARCH_ABORT_EN
        if (abort) state_next = FINISH;
`endif
      end
      WAIT: begin
`ifdef MIN_SEARCH_ABORT_EN
        if (abort) state_next = FINISH;
        else
`endif
        if (alu_valid) begin
          // Earlier groups sit at lower addresses, so strict-less keeps them on ties.
          if (red_valid && (red_min < run_min_reg)) begin
            run_min_next  = red_min;
            run_addr_next = addr_reg + ADDR_W'(red_idx);
          end
          addr_next      = addr_reg + ADDR_W'(step);
          remaining_next = remaining_after;
          any_group_next = 1'b1;
          state_next     = (remaining_after == 32'd0) ? FINISH : ISSUE;
        end
      end
      FINISH: begin
        min_value_next = run_min_reg;
        min_addr_next  = run_addr_reg;
        found_next     = any_group_reg;
        done_next      = 1'b1;
        busy_next      = 1'b0;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign alu_req   = (state_reg == ISSUE);
  assign alu_addr  = addr_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign found     = found_reg;
  assign min_value = min_value_reg;
  assign min_addr  = min_addr_reg;

endmodule
